// File: rtl/reg_wb_pkg.sv
// Shared types for the register write-back controller: entry layout and result source tag.
package reg_wb_pkg;
  localparam int XLEN = 32;
  localparam int AW   = 5;

  typedef struct packed {
    logic [AW-1:0]   rd;
    logic [XLEN-1:0] data;
  } wb_entry_t;

  typedef enum logic {PIPE = 1'b0, LU = 1'b1} wb_src_e;
endpackage

// File: rtl/reg_wb_ctrl_if.sv
// Bus between the write-back controller and its neighbours (pipe, long-latency units, ID, regfile).
interface reg_wb_ctrl_if #(
  parameter int XLEN      = 32,
  parameter int AW        = 5,
  parameter int BUF_DEPTH = 2
);
  localparam int CW = $clog2(BUF_DEPTH) + 1;

  logic            pipe_valid;
  logic [AW-1:0]   pipe_rd;
  logic [XLEN-1:0] pipe_data;
  logic            lu_valid;
  logic            lu_ready;
  logic [AW-1:0]   lu_rd;
  logic [XLEN-1:0] lu_data;
  logic            iss_valid;
  logic [AW-1:0]   iss_rd;
  logic [AW-1:0]   rs1;
  logic [AW-1:0]   rs2;
  logic            rs1_busy;
  logic            rs2_busy;
  logic [AW-1:0]   rd;
  logic [XLEN-1:0] din;
  logic            reg_wrt;
  logic [CW-1:0]   buf_count;

  modport slave (
    input  pipe_valid, pipe_rd, pipe_data, lu_valid, lu_rd, lu_data,
           iss_valid, iss_rd, rs1, rs2,
    output lu_ready, rs1_busy, rs2_busy, rd, din, reg_wrt, buf_count
  );

  modport master (
    output pipe_valid, pipe_rd, pipe_data, lu_valid, lu_rd, lu_data,
           iss_valid, iss_rd, rs1, rs2,
    input  lu_ready, rs1_busy, rs2_busy, rd, din, reg_wrt, buf_count
  );
endinterface

// File: rtl/reg_wb_ctrl_fifo.sv
// Synchronous FIFO of write-back entries; head is visible combinationally.
module wb_fifo
  import reg_wb_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  wb_entry_t                  wdata,
  input  logic                       pop,
  output wb_entry_t                  head,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     count
);
  localparam int IW = $clog2(DEPTH);

  wb_entry_t     r_mem [DEPTH];
  logic [IW:0]   r_wptr, r_rptr;
  logic          w_push, w_pop;

  assign count  = r_wptr - r_rptr;
  assign full   = (r_wptr[IW] != r_rptr[IW]) && (r_wptr[IW-1:0] == r_rptr[IW-1:0]);
  assign empty  = (r_wptr == r_rptr);
  assign head   = r_mem[r_rptr[IW-1:0]];
  assign w_push = push && !full;
  assign w_pop  = pop && !empty;

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_wptr <= '0;
      r_rptr <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + 1'b1;
      if (w_pop)  r_rptr <= r_rptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wptr[IW-1:0]] <= wdata;
  end
endmodule

// File: rtl/reg_wb_ctrl.sv
// Register write-back controller: pipe results have priority, LU results are buffered.
// Define REG_WB_BYPASS_EN to let an LU result skip the empty buffer when the pipe is idle.
module reg_wb_ctrl #(
  parameter int XLEN      = 32,
  parameter int AW        = 5,
  parameter int BUF_DEPTH = 2
) (
  input logic          clk_regs,
  input logic          rst,
  reg_wb_ctrl_if.slave bus
);
  import reg_wb_pkg::*;

  localparam int CW = $clog2(BUF_DEPTH) + 1;
  localparam int NR = 2 ** AW;

  wb_entry_t       w_head, w_lu;
  logic            w_full, w_empty, w_push, w_pop, w_acc, w_byp;
  logic [CW-1:0]   w_count;
  logic [NR-1:0]   r_pending, w_pending_nxt;
  logic [AW-1:0]   r_rd;
  logic [XLEN-1:0] r_din;
  logic            r_wrt;
  wb_src_e         r_wb_src;

  assign w_lu  = '{rd: bus.lu_rd, data: bus.lu_data};
  assign w_acc = bus.lu_valid && bus.lu_ready;
`ifdef REG_WB_BYPASS_EN
  assign w_byp = w_acc && w_empty && !bus.pipe_valid;
`else
  assign w_byp = 1'b0;
`endif
  assign w_push = w_acc && !w_byp;
  assign w_pop  = !bus.pipe_valid && !w_empty;

  wb_fifo #(.DEPTH(BUF_DEPTH)) u_fifo (
    .clk   (clk_regs),
    .rst   (rst),
    .push  (w_push),
    .wdata (w_lu),
    .pop   (w_pop),
    .head  (w_head),
    .full  (w_full),
    .empty (w_empty),
    .count (w_count)
  );

  // Ready uses the pre-pop occupancy, so a full buffer never accepts even while draining.
  assign bus.lu_ready  = rst && !w_full;
  assign bus.buf_count = w_count;
  assign bus.rd        = r_rd;
  assign bus.din       = r_din;
  assign bus.reg_wrt   = r_wrt;
  assign bus.rs1_busy  = (bus.rs1 != '0) && r_pending[bus.rs1];
  assign bus.rs2_busy  = (bus.rs2 != '0) && r_pending[bus.rs2];

  always_ff @(posedge clk_regs) begin
    if (!rst) begin
      r_rd     <= '0;
      r_din    <= '0;
      r_wrt    <= 1'b0;
      r_wb_src <= PIPE;
    end else if (bus.pipe_valid) begin
      r_rd     <= bus.pipe_rd;
      r_din    <= bus.pipe_data;
      r_wrt    <= 1'b1;
      r_wb_src <= PIPE;
    end else if (w_pop) begin
      r_rd     <= w_head.rd;
      r_din    <= w_head.data;
      r_wrt    <= (w_head.rd != '0);
      r_wb_src <= LU;
    end else if (w_byp) begin
      r_rd     <= w_lu.rd;
      r_din    <= w_lu.data;
      r_wrt    <= (w_lu.rd != '0);
      r_wb_src <= LU;
    end else begin
      r_wrt    <= 1'b0;
    end
  end

  // Clear applied before set so an issue to the committing register keeps its bit.
  always_comb begin
    w_pending_nxt = r_pending;
    if (r_wrt && r_wb_src == LU) w_pending_nxt[r_rd] = 1'b0;
    if (bus.iss_valid && bus.iss_rd != '0) w_pending_nxt[bus.iss_rd] = 1'b1;
  end

  always_ff @(posedge clk_regs) begin
    if (!rst) r_pending <= '0;
    else      r_pending <= w_pending_nxt;
  end
endmodule

// File: tb/tb_reg_wb_ctrl.sv
// Directed self-checking bench for reg_wb_ctrl.
module tb_reg_wb_ctrl;
  logic clk_regs = 1'b0;
  logic rst;
  int   n_cmp = 0;
  int   n_err = 0;

  always #5 clk_regs = ~clk_regs;

  reg_wb_ctrl_if #(.XLEN(32), .AW(5), .BUF_DEPTH(2)) bus ();

  reg_wb_ctrl #(.XLEN(32), .AW(5), .BUF_DEPTH(2)) dut (
    .clk_regs (clk_regs),
    .rst      (rst),
    .bus      (bus)
  );

  task automatic tick();
    @(posedge clk_regs);
    #1;
  endtask

  task automatic idle();
    bus.pipe_valid = 0; bus.pipe_rd = 0; bus.pipe_data = 0;
    bus.lu_valid = 0; bus.lu_rd = 0; bus.lu_data = 0;
    bus.iss_valid = 0; bus.iss_rd = 0;
  endtask

  task automatic test_reset();
    rst = 0; idle(); bus.rs1 = 0; bus.rs2 = 0;
    tick(); tick();
    n_cmp++; if (bus.reg_wrt !== 1'b0) begin n_err++; $display("FAIL reset_wrt got %0b want 0", bus.reg_wrt); end
    n_cmp++; if (bus.rd !== 5'd0 || bus.din !== 32'd0) begin n_err++; $display("FAIL reset_rd_din got %0d/%h want 0/0", bus.rd, bus.din); end
    n_cmp++; if (bus.buf_count !== 2'd0) begin n_err++; $display("FAIL reset_count got %0d want 0", bus.buf_count); end
    n_cmp++; if (bus.lu_ready !== 1'b0) begin n_err++; $display("FAIL reset_ready got %0b want 0", bus.lu_ready); end
    bus.rs1 = 7; bus.rs2 = 31; #1;
    n_cmp++; if (bus.rs1_busy !== 1'b0 || bus.rs2_busy !== 1'b0) begin n_err++; $display("FAIL reset_busy got %0b%0b want 00", bus.rs1_busy, bus.rs2_busy); end
    rst = 1; #1;
    n_cmp++; if (bus.lu_ready !== 1'b1) begin n_err++; $display("FAIL ready_after_reset got %0b want 1", bus.lu_ready); end
  endtask

  task automatic test_pipe();
    bus.rs1 = 5; bus.rs2 = 5;
    bus.pipe_valid = 1; bus.pipe_rd = 5; bus.pipe_data = 32'h1234;
    tick();
    idle();
    n_cmp++; if (bus.reg_wrt !== 1'b1 || bus.rd !== 5'd5 || bus.din !== 32'h1234) begin n_err++; $display("FAIL pipe_write got %0b/%0d/%h want 1/5/1234", bus.reg_wrt, bus.rd, bus.din); end
    n_cmp++; if (bus.rs1_busy !== 1'b0 || bus.rs2_busy !== 1'b0) begin n_err++; $display("FAIL pipe_busy got %0b%0b want 00", bus.rs1_busy, bus.rs2_busy); end
    tick();
    n_cmp++; if (bus.reg_wrt !== 1'b0) begin n_err++; $display("FAIL pipe_idle got %0b want 0", bus.reg_wrt); end
  endtask

  task automatic test_lu_path();
    bus.rs1 = 7;
    bus.iss_valid = 1; bus.iss_rd = 7;
    tick();
    idle();
    n_cmp++; if (bus.rs1_busy !== 1'b1) begin n_err++; $display("FAIL lu_busy_set got %0b want 1", bus.rs1_busy); end
    bus.lu_valid = 1; bus.lu_rd = 7; bus.lu_data = 32'hCAFE; #1;
    n_cmp++; if (bus.lu_ready !== 1'b1) begin n_err++; $display("FAIL lu_ready got %0b want 1", bus.lu_ready); end
    tick();
    idle();
`ifndef REG_WB_BYPASS_EN
    n_cmp++; if (bus.reg_wrt !== 1'b0 || bus.buf_count !== 2'd1) begin n_err++; $display("FAIL lu_buffered got %0b/%0d want 0/1", bus.reg_wrt, bus.buf_count); end
    tick();
`endif
    n_cmp++; if (bus.reg_wrt !== 1'b1 || bus.rd !== 5'd7 || bus.din !== 32'hCAFE) begin n_err++; $display("FAIL lu_write got %0b/%0d/%h want 1/7/cafe", bus.reg_wrt, bus.rd, bus.din); end
    n_cmp++; if (bus.rs1_busy !== 1'b1) begin n_err++; $display("FAIL lu_busy_hold got %0b want 1", bus.rs1_busy); end
    tick();
    n_cmp++; if (bus.rs1_busy !== 1'b0 || bus.reg_wrt !== 1'b0) begin n_err++; $display("FAIL lu_busy_clear got %0b/%0b want 0/0", bus.rs1_busy, bus.reg_wrt); end
  endtask

  task automatic test_priority_full();
    logic [4:0]  exp_rd [7];
    logic [31:0] exp_d  [7];
    int k = 0, n = 0;
    logic acc;
    for (int i = 0; i < 4; i++) begin exp_rd[i] = 5'(10 + i); exp_d[i] = 32'h100 + 32'(i); end
    for (int i = 0; i < 3; i++) begin exp_rd[4+i] = 5'(20 + i); exp_d[4+i] = 32'h200 + 32'(i); end
    for (int c = 0; c < 12; c++) begin
      bus.pipe_valid = (c < 4); bus.pipe_rd = 5'(10 + c); bus.pipe_data = 32'h100 + 32'(c);
      bus.lu_valid = (k < 3); bus.lu_rd = 5'(20 + k); bus.lu_data = 32'h200 + 32'(k);
      #1;
      if (c == 2) begin
        n_cmp++; if (bus.lu_ready !== 1'b0) begin n_err++; $display("FAIL full_ready got %0b want 0", bus.lu_ready); end
        n_cmp++; if (bus.buf_count !== 2'd2) begin n_err++; $display("FAIL full_count got %0d want 2", bus.buf_count); end
        n_cmp++; if (k !== 2) begin n_err++; $display("FAIL full_accepts got %0d want 2", k); end
      end
      acc = bus.lu_valid && bus.lu_ready;
      tick();
      if (acc) k++;
      if (bus.reg_wrt === 1'b1) begin
        n_cmp++;
        if (n >= 7 || bus.rd !== exp_rd[n] || bus.din !== exp_d[n]) begin
          n_err++; $display("FAIL prio_order idx %0d got %0d/%h", n, bus.rd, bus.din);
        end
        n++;
      end
    end
    idle();
    n_cmp++; if (n !== 7 || k !== 3) begin n_err++; $display("FAIL prio_total got %0d writes %0d accepts want 7/3", n, k); end
    n_cmp++; if (bus.buf_count !== 2'd0) begin n_err++; $display("FAIL prio_drain got %0d want 0", bus.buf_count); end
  endtask

  task automatic test_x0();
    bus.lu_valid = 1; bus.lu_rd = 0; bus.lu_data = 32'hDEAD;
    tick();
    idle();
    n_cmp++; if (bus.reg_wrt !== 1'b0) begin n_err++; $display("FAIL x0_wrt1 got %0b want 0", bus.reg_wrt); end
    tick();
    n_cmp++; if (bus.reg_wrt !== 1'b0 || bus.buf_count !== 2'd0) begin n_err++; $display("FAIL x0_pop got %0b/%0d want 0/0", bus.reg_wrt, bus.buf_count); end
    bus.iss_valid = 1; bus.iss_rd = 0;
    tick();
    idle();
    bus.rs1 = 0; bus.rs2 = 0; #1;
    n_cmp++; if (bus.rs1_busy !== 1'b0 || bus.rs2_busy !== 1'b0 || dut.r_pending !== 32'd0) begin n_err++; $display("FAIL x0_busy got %0b/%h want 0/0", bus.rs1_busy, dut.r_pending); end
  endtask

  task automatic test_collision();
    int w = 0;
    bus.rs1 = 9;
    bus.iss_valid = 1; bus.iss_rd = 9;
    tick();
    idle();
    bus.lu_valid = 1; bus.lu_rd = 9; bus.lu_data = 32'h99;
    tick();
    idle();
    while (bus.reg_wrt !== 1'b1 && w < 4) begin tick(); w++; end
    n_cmp++; if (bus.reg_wrt !== 1'b1 || bus.rd !== 5'd9) begin n_err++; $display("FAIL coll_commit got %0b/%0d want 1/9", bus.reg_wrt, bus.rd); end
    bus.iss_valid = 1; bus.iss_rd = 9;
    tick();
    idle();
    n_cmp++; if (bus.rs1_busy !== 1'b1) begin n_err++; $display("FAIL coll_setwins got %0b want 1", bus.rs1_busy); end
    tick();
    n_cmp++; if (bus.rs1_busy !== 1'b1) begin n_err++; $display("FAIL coll_persist got %0b want 1", bus.rs1_busy); end
  endtask

  task automatic test_reset_mid();
    bus.rs1 = 3;
    bus.pipe_valid = 1; bus.pipe_rd = 1; bus.pipe_data = 32'h11;
    bus.iss_valid = 1; bus.iss_rd = 3;
    bus.lu_valid = 1; bus.lu_rd = 3; bus.lu_data = 32'h33;
    tick();
    bus.iss_valid = 0;
    bus.lu_rd = 4; bus.lu_data = 32'h44;
    tick();
    bus.lu_valid = 0;
    n_cmp++; if (bus.buf_count !== 2'd2 || bus.rs1_busy !== 1'b1) begin n_err++; $display("FAIL mid_setup got %0d/%0b want 2/1", bus.buf_count, bus.rs1_busy); end
    idle();
    rst = 0;
    tick();
    n_cmp++; if (bus.buf_count !== 2'd0 || bus.reg_wrt !== 1'b0 || bus.rs1_busy !== 1'b0) begin n_err++; $display("FAIL mid_reset got %0d/%0b/%0b want 0/0/0", bus.buf_count, bus.reg_wrt, bus.rs1_busy); end
    n_cmp++; if (bus.lu_ready !== 1'b0) begin n_err++; $display("FAIL mid_ready_low got %0b want 0", bus.lu_ready); end
    rst = 1; #1;
    n_cmp++; if (bus.lu_ready !== 1'b1) begin n_err++; $display("FAIL mid_ready_high got %0b want 1", bus.lu_ready); end
    for (int c = 0; c < 4; c++) begin
      tick();
      n_cmp++; if (bus.reg_wrt !== 1'b0) begin n_err++; $display("FAIL mid_stale cyc %0d got %0b want 0", c, bus.reg_wrt); end
    end
  endtask

  initial begin
    test_reset();
    test_pipe();
    test_lu_path();
    test_priority_full();
    test_x0();
    test_collision();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/reg_wb_ctrl.md
# reg_wb_ctrl

Write-back controller that drives the register file's single write port (`rd`, `din`, `reg_wrt`). It merges two result sources into at most one register write per cycle.
- The in-order single-cycle pipeline result has fixed priority and never stalls.
- Long-latency unit results (mul/div/load) are accepted through a valid/ready handshake and buffered.
- It also keeps a pending-destination scoreboard, so ID can stall on sources whose long-latency write has not yet committed.

## Interface
Parameters:
- `XLEN`, 32, data width
- `AW`, 5, register address width
- `BUF_DEPTH`, 2, long-latency result buffer entries (power of two, ≥2)

Ports:
- `clk_regs`  in  1  clock, all state on rising edge
- `rst`  in  1  reset, synchronous, active-low
- `pipe_valid`  in  1  single-cycle result valid; no back-pressure
- `pipe_rd`  in  AW  pipeline destination
- `pipe_data`  in  XLEN  pipeline result
- `lu_valid`  in  1  long-latency result valid
- `lu_ready`  out  1  buffer can accept; `lu_ready = rst && (count < BUF_DEPTH)`
- `lu_rd`  in  AW  long-latency destination
- `lu_data`  in  XLEN  long-latency result
- `iss_valid`  in  1  ID issues a long-latency op this cycle
- `iss_rd`  in  AW  destination of issued op
- `rs1`, `rs2`  in  AW  ID source indices
- `rs1_busy`, `rs2_busy`  out  1  combinational: `pending[rsN]`; always 0 for x0
- `rd`  out  AW  register file write address (registered)
- `din`  out  XLEN  register file write data (registered)
- `reg_wrt`  out  1  register file write enable (registered)
- `buf_count`  out  $clog2(BUF_DEPTH)+1  buffer occupancy

## Operation
- Reset (`rst`=0 at an edge): `rd`=0, `din`=0, `reg_wrt`=0, buffer empty, `buf_count`=0, `pending`=0, internal `wb_src`=0. `lu_ready`=0 while `rst` is low.
- Accept: a `lu_valid && lu_ready` edge pushes {`lu_rd`,`lu_data`} into the FIFO.
- Select, evaluated each cycle:
  - `pipe_valid` → output registers load the pipe result, with `wb_src`=PIPE.
  - Else, FIFO non-empty → output registers load the head entry and pop it, with `wb_src`=LU.
  - Else → `reg_wrt`<=0.
- Push and pop in the same cycle are legal; occupancy is unchanged. A full buffer with a simultaneous pop still drops `lu_ready`, because `lu_ready` uses the pre-pop count.
- x0: an entry with rd=0 is selected and popped normally, but `reg_wrt` is forced to 0.
- Scoreboard (`pending`, 32 bits):
  - Set at the edge where `iss_valid && iss_rd!=0`.
  - Cleared at the edge where `reg_wrt && wb_src==LU`, for bit `rd`. This is the same edge the register file commits.
  - Set and clear of the same index in one cycle: set wins.
- WAW:
  - A pipe write to a pending rd is performed; `pending` is unaffected. ID must not issue such a sequence.
  - Two outstanding long-latency ops to the same rd are unsupported.
- Starvation: sustained `pipe_valid` holds the FIFO. `lu_ready` drops when full; no data is lost.

## Timing
- Pipe result presented in cycle t → `reg_wrt`=1 in t+1 → committed at end of t+1.
- LU handshake in cycle t (buffer path) → head in t+1 → `reg_wrt` in t+2 (if no pipe result in t+1) → busy clears from t+3.
- `rs*_busy` is combinational from `pending`; an issue in cycle t shows busy from t+1.
- Reset mid-operation discards buffered results and pending bits; the first accept is possible in the first cycle with `rst`=1.

## Configuration
- `REG_WB_BYPASS_EN` defined:
  - When the FIFO is empty, `pipe_valid`=0 and `lu_valid`=1, the LU result bypasses the FIFO directly into the output registers. Latency is handshake t → `reg_wrt` t+1.
  - The FIFO is not pushed in that case.
- Undefined: all LU results go through the FIFO (latency 2).

## Structure
- Package `reg_wb_pkg`:
  - `XLEN`, `AW` constants
  - `wb_entry_t` struct {rd, data}
  - `wb_src_e` enum {PIPE, LU}
- Sub-module `wb_fifo`: synchronous FIFO of `wb_entry_t`.
  - Ports: push, pop, full, empty, count; head is read combinationally.
  - Wrap-around via pointers one bit wider than the index.

## Test plan
- Pipe only: `pipe_valid`=1, rd=5, data=0x1234 at t → `reg_wrt`=1, `rd`=5, `din`=0x1234 at t+1; `rs*_busy` never set.
- LU path:
  - `iss_valid`, `iss_rd`=7 at t0 → `rs1_busy`=1 for `rs1`=7 from t0+1.
  - LU result rd=7, 0xCAFE at t1 → `reg_wrt` at t1+2 (t1+1 with `REG_WB_BYPASS_EN`).
  - `rs1_busy`=0 from the cycle after `reg_wrt`.
- Priority/full:
  - `pipe_valid` held for 4 cycles while LU offers 3 results → `lu_ready` low after 2 accepts.
  - The 4 pipe writes come first, then the LU writes in order.
  - `buf_count` reaches 2.
- x0: LU result rd=0 → popped, `reg_wrt` stays 0, no pending change; `iss_rd`=0 → no busy.
- Set/clear collision: LU write to rd=9 committing in the same cycle as `iss_valid` with rd=9 → `pending[9]` stays 1.
- Reset mid-operation: buffer holding 2 entries, `pending[3]`=1, `rst`=0 for one edge → `buf_count`=0, `reg_wrt`=0, busy 0. No stale write appears afterwards.
